// File: rtl/sprite_pkg.sv
// Shared types and constants for the watermelon sprite pixel pipeline.
package sprite_pkg;

  typedef logic signed [10:0] coord_t;
  typedef logic [3:0]         pix_idx_t;

  localparam pix_idx_t    TRANSPARENT_IDX = 4'h0;
  localparam int          SCREEN_W        = 640;
  localparam int          SCREEN_H        = 480;
  localparam logic [10:0] CNT_MAX         = 11'h7FF;

endpackage

// File: rtl/sprite_delay_line.sv
// Fixed-depth shift register. It aligns a flag with a pipelined data path, and it
// is also used to delay the sync signals by the same amount.
module sprite_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  // NOTE: every stage is reset so a mid-line reset cannot release a stale flag later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/watermelon_sprite_fetch.sv
// Watermelon sprite front end: raster position -> ROM address -> palette index/hit,
// plus per-frame opaque pixel count. Optional WATERMELON_FLIP_EN adds horizontal mirroring.
module watermelon_sprite_fetch
  import sprite_pkg::*;
#(
  parameter int SPR_W   = 32,
  parameter int SPR_H   = 32,
  parameter int ADDR_W  = 10,
  parameter int ROM_LAT = 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic [10:0]       pos_x,
  input  logic [10:0]       pos_y,
  input  logic              visible,
  input  logic              de,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        pix_index,
  output logic              pix_hit,
  output logic [10:0]       drawn_count
`ifdef WATERMELON_FLIP_EN
  ,
  input  logic              flip_x
`endif
);

  localparam logic signed [11:0] SPR_W12 = 12'(SPR_W);
  localparam logic signed [11:0] SPR_H12 = 12'(SPR_H);

  coord_t sx_q, sy_q;
  logic   svis_q;
`ifdef WATERMELON_FLIP_EN
  logic   sflip_q;
`endif

  logic signed [11:0] dx, dy, dx_eff;
  logic               in_box;
  logic [ADDR_W-1:0]  addr;

  logic [ADDR_W-1:0]  rom_addr_q;
  logic               hit1_q, hit_d;
  logic               pix_hit_next;
  logic               pix_hit_q;
  pix_idx_t           pix_index_q;
  logic [10:0]        run_q, drawn_q;

  // Shadow copies change only at frame boundaries so a frame never tears.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sx_q    <= '0;
      sy_q    <= '0;
      svis_q  <= 1'b0;
`ifdef WATERMELON_FLIP_EN
      sflip_q <= 1'b0;
`endif
    end else if (frame_start) begin
      sx_q    <= coord_t'(pos_x);
      sy_q    <= coord_t'(pos_y);
      svis_q  <= visible;
`ifdef WATERMELON_FLIP_EN
      sflip_q <= flip_x;
`endif
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    dx     = $signed({2'b00, draw_x}) - $signed({sx_q[10], sx_q});
    dy     = $signed({2'b00, draw_y}) - $signed({sy_q[10], sy_q});
    in_box = de & svis_q
           & (draw_x < 10'(SCREEN_W)) & (draw_y < 10'(SCREEN_H))
           & !dx[11] & (dx < SPR_W12)
           & !dy[11] & (dy < SPR_H12);
`ifdef WATERMELON_FLIP_EN
    dx_eff = sflip_q ? (SPR_W12 - 12'sd1 - dx) : dx;
`else
    dx_eff = dx;
`endif
    addr   = ADDR_W'(unsigned'(dy)) * ADDR_W'(SPR_W) + ADDR_W'(unsigned'(dx_eff));
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q <= '0;
      hit1_q     <= 1'b0;
    end else begin
      rom_addr_q <= in_box ? addr : '0;
      hit1_q     <= in_box;
    end
  end

  sprite_delay_line #(
    .DEPTH (ROM_LAT),
    .WIDTH (1)
  ) u_hit_dly (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .d_i   (hit1_q),
    .q_o   (hit_d)
  );

  assign pix_hit_next = hit_d & (rom_q != TRANSPARENT_IDX);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_hit_q   <= 1'b0;
      pix_index_q <= TRANSPARENT_IDX;
    end else begin
      pix_hit_q   <= pix_hit_next;
      pix_index_q <= pix_hit_next ? rom_q : TRANSPARENT_IDX;
    end
  end

  // A hit landing on frame_start belongs to the frame that is just beginning.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= '0;
      drawn_q <= '0;
    end else if (frame_start) begin
      drawn_q <= run_q;
      run_q   <= {10'b0, pix_hit_next};
    end else if (pix_hit_next && (run_q != CNT_MAX)) begin
      run_q   <= run_q + 11'd1;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign pix_hit     = pix_hit_q;
  assign pix_index   = pix_index_q;
  assign drawn_count = drawn_q;

endmodule

// File: tb/tb_watermelon_sprite_fetch.sv
// Scoreboard bench for watermelon_sprite_fetch with a 1-cycle model ROM.
module tb_watermelon_sprite_fetch;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } pix_exp_t;

  logic               vga_clk = 1'b0;
  logic               reset_n;
  logic               frame_start;
  logic signed [10:0] pos_x, pos_y;
  logic               visible;
  logic               de;
  logic [9:0]         draw_x, draw_y;
  logic [9:0]         rom_addr;
  logic [3:0]         rom_q;
  logic [3:0]         pix_index;
  logic               pix_hit;
  logic [10:0]        drawn_count;
  logic               flip_x;

  logic [3:0] rom_mem [1024];

  pix_exp_t pix_q[$];
  int       addr_q[$];

  int   m_sx, m_sy, m_run, m_drawn;
  logic m_vis, m_flip;
  int   n_checks = 0;
  int   n_pass   = 0;

  watermelon_sprite_fetch dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .visible     (visible),
    .de          (de),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .pix_index   (pix_index),
    .pix_hit     (pix_hit),
    .drawn_count (drawn_count)
`ifdef WATERMELON_FLIP_EN
    ,
    .flip_x      (flip_x)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  always_ff @(posedge vga_clk) rom_q <= rom_mem[rom_addr];

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  function automatic void model_pix(input int x, input int y, input logic d,
                                    output logic h, output logic [3:0] ix, output int a);
    int dx, dy;
    logic inb;
    dx  = x - m_sx;
    dy  = y - m_sy;
    inb = d && m_vis && dx >= 0 && dx < 32 && dy >= 0 && dy < 32;
    if (m_flip) dx = 31 - dx;
    a   = inb ? dy * 32 + dx : 0;
    h   = inb && (rom_mem[a] != 4'h0);
    ix  = h ? rom_mem[a] : 4'h0;
  endfunction

  // One pixel clock: compare what is due now, advance the model, drive the next pixel.
  task automatic step(input logic fs, input logic d, input int x, input int y);
    pix_exp_t e;
    logic h, hn;
    logic [3:0] ix;
    int a;
    @(negedge vga_clk);
    check("rom_addr", int'(rom_addr), addr_q.pop_front());
    e = pix_q.pop_front();
    check("pix_hit", int'(pix_hit), int'(e.hit));
    check("pix_index", int'(pix_index), int'(e.idx));
    check("drawn_count", int'(drawn_count), m_drawn);
    hn = pix_q[0].hit;
    if (fs) begin
      m_drawn = m_run;
      m_run   = hn ? 1 : 0;
    end else if (hn && m_run < 2047) begin
      m_run++;
    end
    model_pix(x, y, d, h, ix, a);
    pix_q.push_back('{hit: h, idx: ix});
    addr_q.push_back(a);
    if (fs) begin
      m_sx   = int'(pos_x);
      m_sy   = int'(pos_y);
      m_vis  = visible;
`ifdef WATERMELON_FLIP_EN
      m_flip = flip_x;
`endif
    end
    frame_start = fs;
    de          = d;
    draw_x      = 10'(x);
    draw_y      = 10'(y);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
  endtask

  task automatic frame();
    idle(4);
    step(1'b1, 1'b0, 0, 0);
    idle(1);
  endtask

  task automatic raster(input int x0, input int x1, input int y0, input int y1, input logic d);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) step(1'b0, d, x, y);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    frame_start = 1'b0;
    de = 1'b0;
    draw_x = '0;
    draw_y = '0;
    #1;
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_pix_hit", int'(pix_hit), 0);
    check("rst_pix_index", int'(pix_index), 0);
    check("rst_drawn", int'(drawn_count), 0);
    m_sx = 0; m_sy = 0; m_vis = 1'b0; m_flip = 1'b0; m_run = 0; m_drawn = 0;
    pix_q.delete();
    addr_q.delete();
    repeat (3) pix_q.push_back('0);
    addr_q.push_back(0);
    repeat (2) @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  initial begin
    pos_x = '0; pos_y = '0; visible = 1'b0; flip_x = 1'b0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 4'((i % 15) + 1);
    rom_mem[5] = 4'h0;
    rom_mem[6] = 4'h3;
    do_reset();

    // Basic hit path, transparent and coloured texels.
    pos_x = 11'sd100; pos_y = 11'sd50; visible = 1'b1;
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 100, 50);
    step(1'b0, 1'b1, 105, 50);
    step(1'b0, 1'b1, 106, 50);
    raster(96, 135, 48, 83, 1'b1);
    frame();

    // All-opaque sprite over a full frame.
    rom_mem[5] = 4'h1;
    raster(96, 135, 48, 83, 1'b1);
    frame();
    check("frame_1024", int'(drawn_count), 1024);

    // Sprite hanging off the left and bottom edges.
    pos_x = -11'sd8; pos_y = 11'sd470;
    frame();
    step(1'b0, 1'b1, 0, 470);
    raster(0, 39, 465, 479, 1'b1);
    raster(600, 639, 465, 479, 1'b1);
    frame();
    check("edge_count", int'(drawn_count), 241);

    // Position change mid-frame waits for frame_start.
    pos_x = 11'sd100; pos_y = 11'sd50;
    frame();
    pos_x = 11'sd300; pos_y = 11'sd200;
    raster(96, 135, 50, 51, 1'b1);
    raster(296, 335, 200, 201, 1'b1);
    frame();
    check("old_pos_count", int'(drawn_count), 64);
    raster(96, 135, 50, 51, 1'b1);
    raster(296, 335, 200, 201, 1'b1);
    frame();
    check("new_pos_count", int'(drawn_count), 64);

    // Fully off-screen to the right and to the left.
    pos_x = 11'sd640; pos_y = 11'sd50;
    frame();
    raster(600, 639, 45, 85, 1'b1);
    frame();
    check("off_right", int'(drawn_count), 0);
    pos_x = -11'sd32;
    frame();
    raster(0, 39, 45, 85, 1'b1);
    frame();
    check("off_left", int'(drawn_count), 0);

    // Hidden sprite, then display disabled.
    pos_x = 11'sd100; pos_y = 11'sd50; visible = 1'b0;
    frame();
    raster(96, 135, 48, 83, 1'b1);
    frame();
    check("invisible", int'(drawn_count), 0);
    visible = 1'b1;
    frame();
    raster(96, 135, 48, 83, 1'b0);
    frame();
    check("de_low", int'(drawn_count), 0);

    // Counter saturation.
    raster(96, 135, 48, 83, 1'b1);
    raster(96, 135, 48, 83, 1'b1);
    frame();
    check("saturate", int'(drawn_count), 2047);

    // Hit coinciding with frame_start counts toward the new frame.
    frame();
    step(1'b0, 1'b1, 100, 50);
    step(1'b0, 1'b1, 101, 50);
    step(1'b1, 1'b1, 102, 50);
    step(1'b0, 1'b1, 103, 50);
    check("coinc_old", int'(drawn_count), 0);
    frame();
    check("coinc_new", int'(drawn_count), 4);

`ifdef WATERMELON_FLIP_EN
    flip_x = 1'b1;
    frame();
    step(1'b0, 1'b1, 100, 50);
    #7;
    check("flip_addr", int'(rom_addr), 31);
    idle(4);
    flip_x = 1'b0;
    frame();
`endif

    // Asynchronous reset mid-line while a hit is on the output.
    raster(100, 115, 51, 51, 1'b1);
    #2;
    check("pre_rst_hit", int'(pix_hit), 1);
    do_reset();
    raster(96, 135, 50, 52, 1'b1);
    frame();
    check("post_rst_count", int'(drawn_count), 0);
    raster(96, 135, 50, 50, 1'b1);
    frame();
    check("recover_count", int'(drawn_count), 32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
